// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder and output collector:
// feeder state encoding, drain length and packed DIN lane layout.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_e;

  // Cycles for the last skewed lane to leave the feeder and ripple down every PE row.
  function automatic int unsigned drain_cycles(input int unsigned matrix_size,
                                               input int unsigned num_pe_rows);
    return (matrix_size - 1) + num_pe_rows;
  endfunction

  // Lane j of a packed vector occupies bits [lane_lsb(j)+bw-1 : lane_lsb(j)].
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned data_bw);
    return lane * data_bw;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane data+valid shift register; output is the last stage, so a sample
// entering in cycle t is presented in cycle t+DEPTH.
module skew_delay_line #(
  parameter int DATA_BW = 8,
  parameter int DEPTH   = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [DATA_BW-1:0] data_i,
  input  logic               valid_i,
  output logic [DATA_BW-1:0] data_o,
  output logic               valid_o
);

  logic [DATA_BW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Transmit-side feeder: valid/ready intake, triangular lane skew onto DIN,
// zero flush while the array drains, weight-latch pulse on request.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WEIGHT_BW   = 8,
  parameter int DATA_BW     = 8,
  parameter int MATRIX_SIZE = 128,
  parameter int NUM_PE_ROWS = 128,
  parameter int CNT_BW      = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wl_req,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MATRIX_SIZE*DATA_BW-1:0] in_data,
  input  logic                           in_last,
  output logic                           we_rl,
  output logic [MATRIX_SIZE*DATA_BW-1:0] DIN,
  output logic [MATRIX_SIZE-1:0]         din_valid,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_BW-1:0]              job_beats
);

  localparam int unsigned DRAIN_CYCLES = drain_cycles(MATRIX_SIZE, NUM_PE_ROWS);
  localparam int          DCNT_BW      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_BW-1:0] DRAIN_LOAD = DCNT_BW'(DRAIN_CYCLES - 1);

  if (WEIGHT_BW < 1 || DATA_BW < 1 || CNT_BW < 1) begin : g_bad_width
    $error("systolic_skew_feeder: widths must be at least 1");
  end

  feeder_state_e       state_q;
  logic                ready_en_q;
  logic                we_rl_q;
  logic                busy_q;
  logic                done_q;
  logic [DCNT_BW-1:0]  drain_cnt_q;
  logic [CNT_BW-1:0]   job_beats_q;
  logic [CNT_BW-1:0]   job_beats_inc;
  logic                accept;

  // ready_en_q keeps in_ready low while reset is asserted, even though IDLE is the reset state.
  assign in_ready = ready_en_q &
                    (((state_q == ST_IDLE) & ~wl_req) | (state_q == ST_STREAM));
  assign accept   = in_valid & in_ready;

  assign job_beats_inc = (&job_beats_q) ? job_beats_q : job_beats_q + CNT_BW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ready_en_q  <= 1'b0;
      we_rl_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_cnt_q <= '0;
      job_beats_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      we_rl_q    <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wl_req) begin
            state_q <= ST_LOAD;
            we_rl_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (accept) begin
            job_beats_q <= CNT_BW'(1);
            busy_q      <= 1'b1;
            if (in_last) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= DRAIN_LOAD;
              done_q      <= (DRAIN_LOAD == '0);
            end else begin
              state_q <= ST_STREAM;
            end
          end
        end
        ST_LOAD: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_STREAM: begin
          if (accept) begin
            job_beats_q <= job_beats_inc;
            if (in_last) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= DRAIN_LOAD;
              done_q      <= (DRAIN_LOAD == '0);
            end
          end
        end
        ST_DRAIN: begin
          // done is registered, so it is raised while the counter steps from 1 to 0.
          if (drain_cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q - DCNT_BW'(1);
            done_q      <= (drain_cnt_q == DCNT_BW'(1));
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign we_rl     = we_rl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign job_beats = job_beats_q;

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_lane
    logic [DATA_BW-1:0] lane_in;
    logic [DATA_BW-1:0] lane_out;
    logic               lane_vld;

    // Non-accepted cycles inject a zero slot so the array sees clean bubbles.
    assign lane_in = accept ? in_data[lane_lsb(j, DATA_BW) +: DATA_BW] : '0;

    skew_delay_line #(
      .DATA_BW (DATA_BW),
      .DEPTH   (j + 1)
    ) u_skew (
      .clk     (clk),
      .rstn    (rstn),
      .data_i  (lane_in),
      .valid_i (accept),
      .data_o  (lane_out),
      .valid_o (lane_vld)
    );

    assign DIN[lane_lsb(j, DATA_BW) +: DATA_BW] = lane_out;
    assign din_valid[j]                          = lane_vld;
  end

endmodule
